ci_fft_frame_sched: RTL and testbench

//  Frame scheduler between ADC reader and radix-2 FFT core in the NIR processing chain.
//  - Collects FFT_VLEN ADC samples per frame, then bursts them into the FFT core.
//  - Tracks the peak non-DC output magnitude and publishes it as max730 or max850.
//  - Alternates the illumination wavelength (led_sel) after every published frame.

---
 rtl/ci_dsp_pkg.sv | 23 ++
 rtl/ci_fft_frame_sched_if.sv | 30 +++
 rtl/ci_peak_track.sv | 32 +++
 rtl/ci_fft_frame_sched.sv | 174 +++++++++++++++++
 tb/tb_ci_fft_frame_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ci_dsp_pkg.sv
// Shared NIR DSP chain definitions: sample/FFT sizes, scheduler FSM encoding, LED wavelength codes.
package ci_dsp_pkg;

  localparam int ADC_DATLEN    = 12;
  localparam int FFT_VLEN      = 16;
  localparam int FFT_VLEN_LOG2 = $clog2(FFT_VLEN);

  typedef logic [ADC_DATLEN-1:0]    sample_t;
  typedef logic [FFT_VLEN_LOG2-1:0] idx_t;

  localparam idx_t IDX_LAST = idx_t'(FFT_VLEN - 1);
  localparam idx_t IDX_ONE  = idx_t'(1);

  localparam logic [2:0] ST_FILL    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_FEED    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_PUBLISH = 3'd4;

  localparam logic LED_730 = 1'b0;
  localparam logic LED_850 = 1'b1;

endpackage

// File: rtl/ci_fft_frame_sched_if.sv
// Signal bundle between the frame scheduler and its ADC reader / FFT core / host neighbours.
interface ci_fft_frame_sched_if;
  import ci_dsp_pkg::*;

  logic    smp_rdy;
  sample_t smp_data;
  logic    fft_start;
  logic    fft_nd;
  sample_t fft_din;
  sample_t fft_dout;
  logic    fft_out_nd;
  logic    fft_ovfl;
  logic    led_sel;
  sample_t max730;
  sample_t max850;
  logic    max_vld;
  logic    frame_drop;
  logic    smp_lost;

  modport master (
    input  smp_rdy, smp_data, fft_dout, fft_out_nd, fft_ovfl,
    output fft_start, fft_nd, fft_din, led_sel, max730, max850, max_vld, frame_drop, smp_lost
  );

  modport slave (
    output smp_rdy, smp_data, fft_dout, fft_out_nd, fft_ovfl,
    input  fft_start, fft_nd, fft_din, led_sel, max730, max850, max_vld, frame_drop, smp_lost
  );

endinterface

// File: rtl/ci_peak_track.sv
// Running unsigned maximum over FFT output bins; the DC bin never contributes, clr restarts at 0.
module ci_peak_track
  import ci_dsp_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    vld,
  input  logic    is_dc,
  input  sample_t din,
  output sample_t peak_nxt
);

  sample_t peak_q, peak_d;

  // Strictly greater: equal magnitudes keep the earlier value.
  always_comb begin
    peak_d = peak_q;
    if (clr)
      peak_d = '0;
    else if (vld && !is_dc && (din > peak_q))
      peak_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_nxt = peak_d;

endmodule

// File: rtl/ci_fft_frame_sched.sv
// Frame scheduler: buffers FFT_VLEN ADC samples, bursts them into the FFT core, publishes the peak bin.
// Optional macro CI_SCHED_SETTLE_EN discards SETTLE_SMP samples after each wavelength toggle.
module ci_fft_frame_sched
  import ci_dsp_pkg::*;
#(
  parameter int DRAIN_TMO  = 255,
  parameter int SETTLE_SMP = 4
)
(
  input  logic clk,
  input  logic rst,
  ci_fft_frame_sched_if.master io
);

  localparam int             TW       = $clog2(DRAIN_TMO + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(DRAIN_TMO - 1);

  logic [2:0]    state_q, state_d;
  idx_t          wcnt_q, wcnt_d;
  idx_t          ocnt_q, ocnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          led_q, led_d;
  sample_t       max730_q, max730_d;
  sample_t       max850_q, max850_d;
  logic          drop_q, drop_d;
  logic          wr_en, abort, smp_take, pk_clr, pk_vld;
  sample_t       pk_nxt;
  sample_t       mem_q [FFT_VLEN];

`ifdef CI_SCHED_SETTLE_EN
  localparam int SW = (SETTLE_SMP > 0) ? $clog2(SETTLE_SMP + 1) : 1;
  logic [SW-1:0] settle_q, settle_d;

  assign smp_take = (settle_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) settle_q <= '0;
    else     settle_q <= settle_d;
  end
`else
  logic [7:0] unused_settle;
  assign unused_settle = 8'(SETTLE_SMP);
  assign smp_take      = 1'b1;
`endif

  assign pk_clr = (state_q == ST_FEED) && (ocnt_q == IDX_LAST) && !io.fft_ovfl;
  assign pk_vld = (state_q == ST_DRAIN) && io.fft_out_nd;

  ci_peak_track u_peak (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .vld      (pk_vld),
    .is_dc    (ocnt_q == '0),
    .din      (io.fft_dout),
    .peak_nxt (pk_nxt)
  );

  // ocnt indexes the read word in FEED and the output bin in DRAIN.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ocnt_d   = ocnt_q;
    tmo_d    = tmo_q;
    led_d    = led_q;
    max730_d = max730_q;
    max850_d = max850_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    abort    = 1'b0;
`ifdef CI_SCHED_SETTLE_EN
    settle_d = settle_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (io.smp_rdy) begin
          if (smp_take) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + IDX_ONE;
            if (wcnt_q == IDX_LAST) state_d = ST_START;
          end
`ifdef CI_SCHED_SETTLE_EN
          else
            settle_d = settle_q - SW'(1);
`endif
        end
      end
      ST_START: begin
        if (io.fft_ovfl) abort = 1'b1;
        else begin
          state_d = ST_FEED;
          ocnt_d  = '0;
        end
      end
      ST_FEED: begin
        if (io.fft_ovfl) abort = 1'b1;
        else begin
          ocnt_d = ocnt_q + IDX_ONE;
          if (ocnt_q == IDX_LAST) begin
            state_d = ST_DRAIN;
            tmo_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (io.fft_ovfl) abort = 1'b1;
        else begin
          if (io.fft_out_nd) ocnt_d = ocnt_q + IDX_ONE;
          // Publish registers land with the last bin so max_vld and max730/850 align.
          if (io.fft_out_nd && (ocnt_q == IDX_LAST)) begin
            state_d = ST_PUBLISH;
            if (led_q == LED_850) max850_d = pk_nxt;
            else                  max730_d = pk_nxt;
          end else if (tmo_q == TMO_LAST)
            abort = 1'b1;
          else
            tmo_d = tmo_q + TW'(1);
        end
      end
      ST_PUBLISH: begin
        led_d   = ~led_q;
        wcnt_d  = '0;
        state_d = ST_FILL;
`ifdef CI_SCHED_SETTLE_EN
        settle_d = SW'(SETTLE_SMP);
`endif
      end
      default: state_d = ST_FILL;
    endcase
    if (abort) begin
      drop_d  = 1'b1;
      state_d = ST_FILL;
      wcnt_d  = '0;
      ocnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      wcnt_q   <= '0;
      ocnt_q   <= '0;
      tmo_q    <= '0;
      led_q    <= LED_730;
      max730_q <= '0;
      max850_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ocnt_q   <= ocnt_d;
      tmo_q    <= tmo_d;
      led_q    <= led_d;
      max730_q <= max730_d;
      max850_q <= max850_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wcnt_q] <= io.smp_data;
  end

  assign io.fft_start  = (state_q == ST_START);
  assign io.fft_nd     = (state_q == ST_FEED);
  assign io.fft_din    = (state_q == ST_FEED) ? mem_q[ocnt_q] : '0;
  assign io.led_sel    = led_q;
  assign io.max730     = max730_q;
  assign io.max850     = max850_q;
  assign io.max_vld    = (state_q == ST_PUBLISH);
  assign io.frame_drop = drop_q;
  assign io.smp_lost   = io.smp_rdy && (state_q != ST_FILL);

endmodule

// File: tb/tb_ci_fft_frame_sched.sv
// Directed + randomized bench for ci_fft_frame_sched with a frame-level reference model.
module tb_ci_fft_frame_sched;
  import ci_dsp_pkg::*;

  logic clk = 1'b0;
  logic rst;

  ci_fft_frame_sched_if bus();

  ci_fft_frame_sched dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  int      st_cnt = 0, mv_cnt = 0, fd_cnt = 0, sl_cnt = 0;
  int      cyc_n = 0, last_nd_cyc = 0, drop_cyc = 0;
  sample_t nd_q[$];
  sample_t cur_s[$];
  sample_t exp_feed[$];
  sample_t o_arr[16];
  int      settle_left = 0;
  logic    exp_led = LED_730;
  sample_t exp730 = '0;
  sample_t exp850 = '0;
  bit      ovfl_noise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs mid-cycle, then advance to just after the next edge.
  task automatic cyc();
    #2;
    cyc_n++;
    if (bus.fft_start)  st_cnt++;
    if (bus.max_vld)    mv_cnt++;
    if (bus.smp_lost)   sl_cnt++;
    if (bus.frame_drop) begin fd_cnt++; drop_cyc = cyc_n; end
    if (bus.fft_nd)     begin nd_q.push_back(bus.fft_din); last_nd_cyc = cyc_n; end
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t ref_peak(input sample_t o[16]);
    sample_t m = '0;
    for (int i = 1; i < 16; i++)
      if (o[i] > m) m = o[i];
    return m;
  endfunction

  task automatic set_frame(input sample_t s[$]);
    cur_s    = s;
    exp_feed = s[settle_left:$];
    settle_left = 0;
  endtask

  task automatic gen_frame();
    sample_t s[$];
    for (int i = 0; i < 16 + settle_left; i++) s.push_back(sample_t'($urandom));
    set_frame(s);
  endtask

  task automatic gen_out(input sample_t pk);
    int idx = $urandom_range(1, 15);
    o_arr[0] = sample_t'($urandom);
    for (int i = 1; i < 16; i++)
      o_arr[i] = (i == idx) ? pk : sample_t'($urandom_range(0, int'(pk) - 1));
  endtask

  task automatic fill();
    for (int i = 0; i < cur_s.size(); i++) begin
      bus.smp_rdy  = 1'b1;
      bus.smp_data = cur_s[i];
      bus.fft_ovfl = ovfl_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      bus.smp_rdy  = 1'b0;
      bus.fft_ovfl = 1'b0;
      if (i < cur_s.size() - 1) repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  task automatic wait_nd(input int n);
    int k = 0;
    while (nd_q.size() < n && k < 60) begin cyc(); k++; end
    chk($sformatf("feed_words_%0d", n), nd_q.size(), n);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      bus.fft_out_nd = 1'b1;
      bus.fft_dout   = o_arr[i];
      cyc();
      bus.fft_out_nd = 1'b0;
      bus.fft_dout   = sample_t'($urandom);
      if (i < n - 1) repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  task automatic run_frame(input bit lost_in_feed);
    int st0 = st_cnt, sl0 = sl_cnt, mv0 = mv_cnt;
    sample_t pk = ref_peak(o_arr);
    nd_q.delete();
    fill();
    if (lost_in_feed) begin
      wait_nd(2);
      bus.smp_rdy  = 1'b1;
      bus.smp_data = 12'hEEE;
      cyc();
      bus.smp_rdy  = 1'b0;
    end
    wait_nd(16);
    for (int i = 0; i < 16 && i < nd_q.size(); i++)
      chk($sformatf("feed_w%0d", i), nd_q[i], exp_feed[i]);
    chk("start_pulses", st_cnt - st0, 1);
    drain(16);
    if (exp_led == LED_730) exp730 = pk;
    else                    exp850 = pk;
    chk("max_vld_after_last_bin", bus.max_vld, 1'b1);
    chk("max730_pub", bus.max730, exp730);
    chk("max850_pub", bus.max850, exp850);
    cyc();
    exp_led = ~exp_led;
`ifdef CI_SCHED_SETTLE_EN
    settle_left = 4;
`endif
    chk("led_sel_toggle", bus.led_sel, exp_led);
    chk("max_vld_pulses", mv_cnt - mv0, 1);
    chk("smp_lost_cnt", sl_cnt - sl0, lost_in_feed ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t s[$];
    int mv0, fd0, k;

    rst = 1'b1;
    bus.smp_rdy = 1'b0; bus.smp_data = '0; bus.fft_dout = '0;
    bus.fft_out_nd = 1'b0; bus.fft_ovfl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led_sel",    bus.led_sel,    1'b0);
    chk("rst_max730",     bus.max730,     12'h0);
    chk("rst_max850",     bus.max850,     12'h0);
    chk("rst_max_vld",    bus.max_vld,    1'b0);
    chk("rst_frame_drop", bus.frame_drop, 1'b0);
    chk("rst_fft_start",  bus.fft_start,  1'b0);
    chk("rst_fft_nd",     bus.fft_nd,     1'b0);
    chk("rst_smp_lost",   bus.smp_lost,   1'b0);
    rst = 1'b0;
    cyc();

    // Samples 1..16, peak 0xABC on 730 nm.
    for (int i = 1; i <= 16; i++) s.push_back(sample_t'(i));
    set_frame(s);
    o_arr[0] = 12'h100; o_arr[1] = 12'h005; o_arr[2] = 12'hABC; o_arr[3] = 12'h010;
    for (int i = 4; i < 16; i++) o_arr[i] = 12'h001;
    run_frame(1'b0);

    // DC bin at full scale must not win.
    gen_frame();
    o_arr[0] = 12'hFFF;
    for (int i = 1; i < 16; i++) o_arr[i] = 12'h020;
    run_frame(1'b0);

    gen_frame(); gen_out(12'h123); run_frame(1'b0);
    gen_frame(); gen_out(12'h456); run_frame(1'b0);
    chk("two_frames_max730", bus.max730, 12'h123);
    chk("two_frames_max850", bus.max850, 12'h456);

    // Overflow in the 5th FEED cycle.
    gen_frame();
    nd_q.delete();
    mv0 = mv_cnt; fd0 = fd_cnt;
    fill();
    wait_nd(4);
    bus.fft_ovfl = 1'b1;
    cyc();
    bus.fft_ovfl = 1'b0;
    repeat (4) cyc();
    chk("ovfl_feed_cut", nd_q.size(), 5);
    chk("ovfl_drop_pulses", fd_cnt - fd0, 1);
    chk("ovfl_no_max_vld", mv_cnt - mv0, 0);
    chk("ovfl_led_kept", bus.led_sel, exp_led);
    chk("ovfl_max730_kept", bus.max730, exp730);
    chk("ovfl_max850_kept", bus.max850, exp850);
    gen_frame(); gen_out(12'h3A5); run_frame(1'b0);

    // Drain timeout after 3 of 16 bins.
    gen_frame();
    nd_q.delete();
    mv0 = mv_cnt; fd0 = fd_cnt;
    fill();
    wait_nd(16);
    gen_out(12'h7FF);
    drain(3);
    k = 0;
    while (fd_cnt == fd0 && k < 400) begin cyc(); k++; end
    chk("tmo_drop_pulses", fd_cnt - fd0, 1);
    chk("tmo_latency_window", ((drop_cyc - last_nd_cyc) >= 255) && ((drop_cyc - last_nd_cyc) <= 257), 1'b1);
    chk("tmo_no_max_vld", mv_cnt - mv0, 0);
    chk("tmo_led_kept", bus.led_sel, exp_led);
    gen_frame(); gen_out(12'h222); run_frame(1'b0);

    gen_frame(); gen_out(12'h0F0); run_frame(1'b1);

    ovfl_noise = 1'b1;
    for (int r = 0; r < 4; r++) begin
      gen_frame();
      for (int i = 0; i < 16; i++) o_arr[i] = sample_t'($urandom);
      run_frame(r[0]);
    end
    ovfl_noise = 1'b0;

`ifdef CI_SCHED_SETTLE_EN
    s.delete();
    for (int i = 0; i < 20; i++) s.push_back(sample_t'(i));
    set_frame(s);
    gen_out(12'h333);
    run_frame(1'b0);
`endif

    // Asynchronous reset in the middle of FEED.
    gen_frame();
    nd_q.delete();
    fill();
    wait_nd(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_fft_nd",     bus.fft_nd,     1'b0);
    chk("arst_fft_din",    bus.fft_din,    12'h0);
    chk("arst_led_sel",    bus.led_sel,    1'b0);
    chk("arst_max730",     bus.max730,     12'h0);
    chk("arst_max850",     bus.max850,     12'h0);
    chk("arst_max_vld",    bus.max_vld,    1'b0);
    chk("arst_frame_drop", bus.frame_drop, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_led = LED_730; exp730 = '0; exp850 = '0; settle_left = 0;
    cyc();
    gen_frame(); gen_out(12'h5A5); run_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
